// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
package muldiv_unit_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Quotient returned for a division by zero
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection for the shared mul/div accumulator.
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2:0]        funct3_i,
  input  logic              neg_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   qr;
  logic [XLEN-1:0]   qr_fix;

  // Negate magnitude results where the latched sign says so, then pick the requested half
  always_comb begin
    prod   = neg_i ? -acc_i : acc_i;
    qr     = funct3_i[1] ? acc_i[2*XLEN-1:XLEN] : acc_i[XLEN-1:0];
    qr_fix = neg_i ? -qr : qr;
    if (funct3_i[2])
      result_o = qr_fix;
    else if (funct3_i == F3_MUL)
      result_o = prod[XLEN-1:0];
    else
      result_o = prod[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add / shift-subtract step per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RA_W-1:0] rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RA_W-1:0] wb_addr,
  output logic            wb_en
);

  localparam int               CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [RA_W-1:0]   wbaddr_q, wbaddr_d;

  logic              accept;
  logic              signed_a, signed_b, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_q;
  logic [2*XLEN-1:0] iter_next;
  logic [XLEN-1:0]   fixed_res;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state_q == ST_IDLE) && start;

  // Operand decode at acceptance: signedness, magnitudes and the no-iteration cases
  always_comb begin
    signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = signed_a && op_a[XLEN-1];
    sb       = signed_b && op_b[XLEN-1];
    abs_a    = abs_val(op_a, sa);
    abs_b    = abs_val(op_b, sb);
    div_zero = funct3[2] && (op_b == '0);
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero || ovf;
    if (div_zero)
      special_res = funct3[1] ? op_a : XLEN'(DIV_ZERO_Q);
    else
      special_res = funct3[1] ? '0 : op_a;
  end

  // One iteration: multiplier sits in acc low half, dividend shifts out of acc low half
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_q     = ~div_diff[XLEN];
    if (f3_q[2])
      iter_next = {(div_q ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_q};
    else
      iter_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .acc_i    (iter_next),
    .funct3_i (f3_q),
    .neg_i    (neg_q),
    .result_o (fixed_res)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = special ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = (state_q == ST_DONE);
    wb_en = done && (wbaddr_q != '0);
  end

  // Datapath next state: latch at acceptance, iterate in RUN, capture result on the last step
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    wbaddr_d = wbaddr_q;
    if (accept) begin
      f3_d     = funct3;
      wbaddr_d = rd_addr;
      neg_d    = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
      cnt_d    = '0;
      if (funct3[2]) begin
        acc_d  = {{XLEN{1'b0}}, abs_a};
        opnd_d = abs_b;
      end else begin
        acc_d  = {{XLEN{1'b0}}, abs_b};
        opnd_d = abs_a;
      end
      if (special) result_d = special_res;
    end else if (state_q == ST_RUN) begin
      acc_d = iter_next;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) result_d = fixed_res;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Control and visible registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      result_q <= '0;
      wbaddr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wbaddr_q <= wbaddr_d;
    end
  end

  // Datapath registers; contents are don't-care until the next acceptance
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    f3_q   <= f3_d;
    neg_q  <= neg_d;
  end

  assign result  = result_q;
  assign wb_addr = wbaddr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_run = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  addr;
    logic        wen;
    int          due;
    int          busy_n;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_addr (wb_addr),
    .wb_en   (wb_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result=%h at cycle %0d want no done", result, cyc);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "/result"},     result,          e.res);
          chk({e.tag, "/wb_addr"},    32'(wb_addr),    32'(e.addr));
          chk({e.tag, "/wb_en"},      32'(wb_en),      32'(e.wen));
          chk({e.tag, "/done_cycle"}, 32'(cyc),        32'(e.due));
          chk({e.tag, "/busy_cycles"},32'(busy_run),   32'(e.busy_n));
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input int lat, input bit spam);
    exp_t e;
    int g;
    @(negedge clk);
    start   = 1'b1;
    funct3  = f3;
    op_a    = a;
    op_b    = b;
    rd_addr = rd;
    e.tag    = tag;
    e.res    = exp_res;
    e.addr   = rd;
    e.wen    = (rd != 5'd0);
    e.due    = cyc + lat;
    e.busy_n = (lat == 33) ? 32 : 0;
    sb.push_back(e);
    @(negedge clk);
    start   = spam;
    op_a    = ~a;
    op_b    = b ^ 32'h5A5A_A5A5;
    funct3  = ~f3;
    rd_addr = rd ^ 5'h1F;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
      if (spam) begin
        op_a = op_a + 32'd3;
        op_b = op_b + 32'd1;
      end
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s/timeout: got no done within %0d cycles want done", tag, g);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset/busy",    32'(busy),    32'd0);
    chk("reset/done",    32'(done),    32'd0);
    chk("reset/wb_en",   32'(wb_en),   32'd0);
    chk("reset/result",  result,       32'd0);
    chk("reset/wb_addr", 32'(wb_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue("mul_7x-3",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
    issue("mulhu_ffff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, 1'b0);
    issue("mulh_ffff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33, 1'b0);
    issue("mulhsu_ffff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 1'b0);
    issue("div_-7/2",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 33, 1'b0);
    issue("rem_-7/2",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 33, 1'b0);
    issue("divu_100/7",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33, 1'b0);
    issue("remu_100/7",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33, 1'b0);
    issue("div_5/0",      3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b0);
    issue("rem_5/0",      3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1,  1'b0);
    issue("remu_5/0",     3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1,  1'b0);
    issue("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1,  1'b0);
    issue("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1,  1'b0);
    issue("divu_big",     3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 33, 1'b0);
    issue("mul_spam",     3'b000, 32'd6,         32'd7,         5'd3,  32'd42,        33, 1'b1);
    issue("mul_rd0",      3'b000, 32'd3,         32'd3,         5'd0,  32'd9,         33, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_addr = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/busy",   32'(busy),   32'd0);
    chk("midrst/done",   32'(done),   32'd0);
    chk("midrst/result", result,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst/idle_busy", 32'(busy), 32'd0);

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; rd_addr = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_start/busy", 32'(busy), 32'd0);
    chk("rst_start/done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue("mul_after_rst", 3'b000, 32'd10, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFF6, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
